// File: rtl/priority_code_serializer.sv
// Sequential 12-to-4 priority encoder: accepts a request vector and emits the code
// of every set bit, highest first, one per handshake, with second-code lookahead.
module priority_code_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  code,
  output logic [3:0]  next_code,
  output logic        last
);

  // state | meaning
  // IDLE  | waiting for a request vector, in_ready=1
  // SCAN  | emitting codes of pend, out_valid=1
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [11:0] pend, pend_nxt;
  logic        empty_flag, empty_nxt;

  logic [3:0]  top_code;
  logic [11:0] pend_rest;
  logic [3:0]  second_code;

  function automatic logic [3:0] highest_code(input logic [11:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) c = 4'(i + 1);
    end
    return c;
  endfunction

  // Pending bits after dropping the one that is currently presented.
  always_comb begin
    top_code  = highest_code(pend);
    pend_rest = pend;
    for (int i = 0; i < 12; i++) begin
      if (top_code == 4'(i + 1)) pend_rest[i] = 1'b0;
    end
    second_code = highest_code(pend_rest);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pend       <= 12'd0;
      empty_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend       <= pend_nxt;
      empty_flag <= empty_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    empty_nxt = empty_flag;
    case (state)
      IDLE: begin
        if (in_valid) begin
          pend_nxt  = req;
          empty_nxt = (req == 12'd0);
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (pend_rest == 12'd0) begin
            state_nxt = IDLE;
            pend_nxt  = 12'd0;
            empty_nxt = 1'b0;
          end else begin
            pend_nxt = pend_rest;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    code      = 4'd0;
    next_code = 4'd0;
    last      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      SCAN: begin
        out_valid = 1'b1;
        code      = empty_flag ? 4'd0 : top_code;
        next_code = second_code;
        last      = (pend_rest == 12'd0);
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_priority_code_serializer.sv
// Directed bench for priority_code_serializer; inputs driven and outputs sampled
// on the falling edge, expected values hand-computed.
module tb_priority_code_serializer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  code;
  logic [3:0]  next_code;
  logic        last;

  int n_cmp;
  int n_err;

  priority_code_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .next_code (next_code),
    .last      (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] c, input logic [3:0] nc,
                          input logic l);
    chk({tag, ".out_valid"}, 16'(out_valid), 16'd1);
    chk({tag, ".in_ready"},  16'(in_ready),  16'd0);
    chk({tag, ".code"},      16'(code),      16'(c));
    chk({tag, ".next_code"}, 16'(next_code), 16'(nc));
    chk({tag, ".last"},      16'(last),      16'(l));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  16'(in_ready),  16'd1);
    chk({tag, ".out_valid"}, 16'(out_valid), 16'd0);
    chk({tag, ".code"},      16'(code),      16'd0);
    chk({tag, ".next_code"}, 16'(next_code), 16'd0);
    chk({tag, ".last"},      16'(last),      16'd0);
  endtask

  // Present a vector for one edge; returns at the falling edge where the first beat shows.
  task automatic accept(input logic [11:0] v);
    in_valid = 1'b1;
    req      = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [3:0] sp_code [3];
  logic [3:0] sp_next [3];

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    req       = 12'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    // full vector, 12 beats
    out_ready = 1'b1;
    accept(12'hFFF);
    for (int i = 0; i < 12; i++) begin
      chk_beat($sformatf("full%0d", i), 4'(12 - i), 4'(11 - i), i == 11);
      @(negedge clk);
    end
    chk_idle("full_done");

    // sparse vector
    sp_code[0] = 4'd12; sp_next[0] = 4'd6;
    sp_code[1] = 4'd6;  sp_next[1] = 4'd1;
    sp_code[2] = 4'd1;  sp_next[2] = 4'd0;
    accept(12'b1000_0010_0001);
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("sparse%0d", i), sp_code[i], sp_next[i], i == 2);
      @(negedge clk);
    end
    chk_idle("sparse_done");

    // empty vector
    accept(12'h000);
    chk_beat("empty", 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    chk_idle("empty_done");

    // back-pressure, req changed during SCAN
    out_ready = 1'b0;
    accept(12'h00C);
    req = 12'hFFF;
    for (int i = 0; i < 5; i++) begin
      chk_beat($sformatf("stall%0d", i), 4'd4, 4'd3, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_beat("bp_second", 4'd3, 4'd0, 1'b1);
    @(negedge clk);
    chk_beat("bp_hold", 4'd3, 4'd0, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle("bp_done");

    // back-to-back with in_valid held high
    in_valid = 1'b1;
    req      = 12'h001;
    @(negedge clk);
    chk_beat("b2b_a", 4'd1, 4'd0, 1'b1);
    req = 12'h800;
    @(negedge clk);
    chk("b2b_gap.in_ready",  16'(in_ready),  16'd1);
    chk("b2b_gap.out_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_beat("b2b_b", 4'd12, 4'd0, 1'b1);
    @(negedge clk);
    chk_idle("b2b_done");

    // reset mid-SCAN
    accept(12'hFFF);
    repeat (3) @(negedge clk);
    chk_beat("pre_rst", 4'd9, 4'd8, 1'b0);
    reset = 1'b1;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    reset = 1'b0;
    accept(12'h003);
    chk_beat("post_rst0", 4'd2, 4'd1, 1'b0);
    @(negedge clk);
    chk_beat("post_rst1", 4'd1, 4'd0, 1'b1);
    @(negedge clk);
    chk_idle("post_rst_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
